mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/arb_lat_timer.sv | 37 +++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/load-store RAM port arbiter.
//   arb_state_e : arbiter FSM states (idle / read outstanding)
//   arb_owner_e : which requester owns the outstanding read
//   BE_ALL      : full-word byte enable driven on reads
package mem_port_arbiter_pkg;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_RD_WAIT = 1'b1} arb_state_e;
  typedef enum logic {OWN_FETCH = 1'b0, OWN_DATA = 1'b1} arb_owner_e;

  localparam logic [3:0] BE_ALL = 4'b1111;

  // READ_LATENCY is 1..7, MAX_DATA_STREAK is 1..15
  localparam int unsigned TIMER_W  = 3;
  localparam int unsigned STREAK_W = 4;

endpackage

// File: rtl/arb_lat_timer.sv
// Loadable down-counter tracking the RAM read latency.
//   clk, rst_n : clock, async active-low reset
//   clk_en     : global advance enable; counter holds when low
//   load       : load load_val (takes priority over decrement)
//   load_val   : latency to count down from
//   done_c     : combinational, counter currently equals 1 (last wait cycle)
module arb_lat_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned CNT_W = TIMER_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done_c
);

  logic [CNT_W-1:0] cnt_q;

  // Count down to zero, one step per enabled cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clk_en) begin
      if (load) begin
        cnt_q <= load_val;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign done_c = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between instruction fetch and
// load/store. Data has priority, bounded by a streak limit while fetch waits.
// One read may be outstanding; its data is routed back to the owner.
//   clk, rst_n, clk_en                  : clock, async active-low reset, advance enable
//   i_fetch_req/addr, o_fetch_gnt       : fetch read request and same-cycle grant
//   o_fetch_rvalid/rdata                : fetch read return (rdata 0 unless rvalid)
//   i_data_req/we/be/addr/wdata, o_data_gnt : load/store request and grant
//   o_data_rvalid/rdata                 : load return (rdata 0 unless rvalid)
//   o_mem_en/we/be/addr/wdata, i_mem_rdata  : RAM port
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 31,
  parameter int unsigned DATA_WIDTH      = 31,
  parameter int unsigned READ_LATENCY    = 1,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  i_fetch_req,
  input  logic [ADDR_WIDTH:0]   i_fetch_addr,
  output logic                  o_fetch_gnt,
  output logic                  o_fetch_rvalid,
  output logic [DATA_WIDTH:0]   o_fetch_rdata,
  input  logic                  i_data_req,
  input  logic                  i_data_we,
  input  logic [3:0]            i_data_be,
  input  logic [ADDR_WIDTH:0]   i_data_addr,
  input  logic [DATA_WIDTH:0]   i_data_wdata,
  output logic                  o_data_gnt,
  output logic                  o_data_rvalid,
  output logic [DATA_WIDTH:0]   o_data_rdata,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [3:0]            o_mem_be,
  output logic [ADDR_WIDTH:0]   o_mem_addr,
  output logic [DATA_WIDTH:0]   o_mem_wdata,
  input  logic [DATA_WIDTH:0]   i_mem_rdata
);

  arb_state_e           state_q, state_d;
  arb_owner_e           owner_q;
  logic [STREAK_W-1:0]  streak_q;
  logic                 fetch_win, data_win;
  logic                 rd_start, rd_done, tmr_done_c;
  logic                 streak_full;

  assign streak_full = (streak_q == STREAK_W'(MAX_DATA_STREAK));

  // Same-cycle winner selection; fetch overrides data only after a full streak
  always_comb begin
    fetch_win = 1'b0;
    data_win  = 1'b0;
    if (state_q == ARB_IDLE && clk_en) begin
      if (i_data_req && !(i_fetch_req && streak_full)) begin
        data_win = 1'b1;
      end else if (i_fetch_req) begin
        fetch_win = 1'b1;
      end
    end
  end

  assign rd_start = fetch_win | (data_win & ~i_data_we);
  assign rd_done  = (state_q == ARB_RD_WAIT) & clk_en & tmr_done_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:    if (rd_start) state_d = ARB_RD_WAIT;
      ARB_RD_WAIT: if (rd_done)  state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  // Owner of the outstanding read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_FETCH;
    end else if (fetch_win) begin
      owner_q <= OWN_FETCH;
    end else if (data_win && !i_data_we) begin
      owner_q <= OWN_DATA;
    end
  end

  // Consecutive data grants while fetch is waiting; saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else if (clk_en) begin
      if (!i_fetch_req || fetch_win) begin
        streak_q <= '0;
      end else if (data_win && !streak_full) begin
        streak_q <= streak_q + STREAK_W'(1);
      end
    end
  end

  arb_lat_timer #(
    .CNT_W (TIMER_W)
  ) u_lat_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .load     (rd_start),
    .load_val (TIMER_W'(READ_LATENCY)),
    .done_c   (tmr_done_c)
  );

  // Outputs; all forced low while reset is asserted, regardless of requests
  always_comb begin
    o_fetch_gnt    = 1'b0;
    o_fetch_rvalid = 1'b0;
    o_fetch_rdata  = '0;
    o_data_gnt     = 1'b0;
    o_data_rvalid  = 1'b0;
    o_data_rdata   = '0;
    o_mem_en       = 1'b0;
    o_mem_we       = 1'b0;
    o_mem_be       = 4'b0000;
    o_mem_addr     = '0;
    o_mem_wdata    = '0;
    if (rst_n) begin
      o_fetch_gnt = fetch_win;
      o_data_gnt  = data_win;
      if (fetch_win) begin
        o_mem_en   = 1'b1;
        o_mem_be   = BE_ALL;
        o_mem_addr = i_fetch_addr;
      end else if (data_win) begin
        o_mem_en   = 1'b1;
        o_mem_we   = i_data_we;
        o_mem_addr = i_data_addr;
        if (i_data_we) begin
          o_mem_be    = i_data_be;
          o_mem_wdata = i_data_wdata;
        end else begin
          o_mem_be    = BE_ALL;
        end
      end
      if (rd_done) begin
        if (owner_q == OWN_FETCH) begin
          o_fetch_rvalid = 1'b1;
          o_fetch_rdata  = i_mem_rdata;
        end else begin
          o_data_rvalid  = 1'b1;
          o_data_rdata   = i_mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Three instances with READ_LATENCY
// 1, 2 and 3 share the same stimulus; each check names the instance it reads.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        fg;
    logic        frv;
    logic [31:0] frd;
    logic        dg;
    logic        drv;
    logic [31:0] drd;
    logic        men;
    logic        mwe;
    logic [3:0]  mbe;
    logic [31:0] maddr;
    logic [31:0] mwd;
  } obs_t;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        freq;
    logic [31:0] faddr;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr;
    logic [31:0] dwd;
    logic [31:0] mrd;
    int          idx;
    obs_t        exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        clk_en;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] mem_rdata;

  obs_t obs [3];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic        fg, frv, dg, drv, men, mwe;
    logic [31:0] frd, drd, maddr, mwd;
    logic [3:0]  mbe;

    mem_port_arbiter #(
      .ADDR_WIDTH      (31),
      .DATA_WIDTH      (31),
      .READ_LATENCY    (g + 1),
      .MAX_DATA_STREAK (4)
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .clk_en         (clk_en),
      .i_fetch_req    (fetch_req),
      .i_fetch_addr   (fetch_addr),
      .o_fetch_gnt    (fg),
      .o_fetch_rvalid (frv),
      .o_fetch_rdata  (frd),
      .i_data_req     (data_req),
      .i_data_we      (data_we),
      .i_data_be      (data_be),
      .i_data_addr    (data_addr),
      .i_data_wdata   (data_wdata),
      .o_data_gnt     (dg),
      .o_data_rvalid  (drv),
      .o_data_rdata   (drd),
      .o_mem_en       (men),
      .o_mem_we       (mwe),
      .o_mem_be       (mbe),
      .o_mem_addr     (maddr),
      .o_mem_wdata    (mwd),
      .i_mem_rdata    (mem_rdata)
    );

    assign obs[g] = {fg, frv, frd, dg, drv, drd, men, mwe, mbe, maddr, mwd};
  end

  function automatic obs_t ob(input logic fg, frv, input logic [31:0] frd,
                              input logic dg, drv, input logic [31:0] drd,
                              input logic men, mwe, input logic [3:0] mbe,
                              input logic [31:0] maddr, mwd);
    ob = {fg, frv, frd, dg, drv, drd, men, mwe, mbe, maddr, mwd};
  endfunction

  function automatic vec_t mkv(input logic r, en, fr, input logic [31:0] fa,
                               input logic dr, dw, input logic [3:0] be,
                               input logic [31:0] da, dwd, mrd,
                               input int idx, input obs_t e);
    vec_t v;
    v.rst_n = r;  v.en = en;   v.freq = fr;  v.faddr = fa;
    v.dreq  = dr; v.dwe = dw;  v.dbe = be;   v.daddr = da;
    v.dwd   = dwd; v.mrd = mrd; v.idx = idx; v.exp = e;
    return v;
  endfunction

  // RAM bus contents only matter while the strobe is up
  function automatic obs_t msk(input obs_t o);
    obs_t m;
    m = o;
    if (!m.men) begin
      m.mwe = 1'b0; m.mbe = 4'b0000; m.maddr = '0; m.mwd = '0;
    end
    return m;
  endfunction

  // Drive one cycle of inputs, check mid low phase, advance to next negedge
  task automatic apply(input vec_t v, input string tag);
    obs_t a, e;
    rst_n = v.rst_n; clk_en = v.en; fetch_req = v.freq; fetch_addr = v.faddr;
    data_req = v.dreq; data_we = v.dwe; data_be = v.dbe; data_addr = v.daddr;
    data_wdata = v.dwd; mem_rdata = v.mrd;
    #2;
    a = msk(obs[v.idx]);
    e = msk(v.exp);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s dut%0d got=%h exp=%h", tag, v.idx, a, e);
    end
    @(negedge clk);
  endtask

  localparam obs_t Z = '0;

  vec_t tbl[$];

  initial begin
    // Latency-1 instance: fetch read, store/load mix, data streak limit
    tbl.push_back(mkv(0,1,1,'h10,1,1,4'hF,'h40,'h1,'h13,0, Z));
    tbl.push_back(mkv(1,1,1,'h10,0,0,4'h0,'h0,'h0,'h13,0, ob(1,0,0,0,0,0,1,0,4'hF,'h10,0)));
    tbl.push_back(mkv(1,1,0,'h0,0,0,4'h0,'h0,'h0,'h13,0, ob(0,1,'h13,0,0,0,0,0,0,0,0)));
    tbl.push_back(mkv(1,1,0,'h0,0,0,4'h0,'h0,'h0,'h13,0, Z));
    tbl.push_back(mkv(1,1,1,'h20,1,1,4'h3,'h40,'hBEEF,'h55,0, ob(0,0,0,1,0,0,1,1,4'h3,'h40,'hBEEF)));
    tbl.push_back(mkv(1,1,1,'h20,0,0,4'h0,'h0,'h0,'h55,0, ob(1,0,0,0,0,0,1,0,4'hF,'h20,0)));
    tbl.push_back(mkv(1,1,0,'h0,0,0,4'h0,'h0,'h0,'h55,0, ob(0,1,'h55,0,0,0,0,0,0,0,0)));
    tbl.push_back(mkv(1,1,0,'h0,1,1,4'h0,'h44,'h1234,'h55,0, ob(0,0,0,1,0,0,1,1,4'h0,'h44,'h1234)));
    tbl.push_back(mkv(1,1,0,'h0,1,0,4'h3,'h48,'hFFFF,'h55,0, ob(0,0,0,1,0,0,1,0,4'hF,'h48,0)));
    tbl.push_back(mkv(1,1,0,'h0,0,0,4'h0,'h0,'h0,'h77,0, ob(0,0,0,0,1,'h77,0,0,0,0,0)));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mkv(1,1,1,'h30,1,1,4'hF,'h50,'hA,'h99,0, ob(0,0,0,1,0,0,1,1,4'hF,'h50,'hA)));
    tbl.push_back(mkv(1,1,1,'h30,1,1,4'hF,'h50,'hA,'h99,0, ob(1,0,0,0,0,0,1,0,4'hF,'h30,0)));
    tbl.push_back(mkv(1,1,0,'h0,1,1,4'hF,'h50,'hA,'h99,0, ob(0,1,'h99,0,0,0,0,0,0,0,0)));
    tbl.push_back(mkv(1,1,0,'h0,1,1,4'hF,'h50,'hA,'h99,0, ob(0,0,0,1,0,0,1,1,4'hF,'h50,'hA)));
    tbl.push_back(mkv(1,1,0,'h0,0,0,4'h0,'h0,'h0,'h99,0, Z));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Latency 3: load returns three cycles after grant, waiting fetch follows
    apply(mkv(0,1,0,'h0,0,0,4'h0,'h0,'h0,'h0,2, Z), "d_rst");
    apply(mkv(1,1,0,'h0,1,0,4'h0,'h60,'h0,'h0,2, ob(0,0,0,1,0,0,1,0,4'hF,'h60,0)), "d_gnt");
    apply(mkv(1,1,1,'h70,0,0,4'h0,'h0,'h0,'hCAFEF00D,2, Z), "d_wait1");
    apply(mkv(1,1,1,'h70,0,0,4'h0,'h0,'h0,'hCAFEF00D,2, Z), "d_wait2");
    apply(mkv(1,1,1,'h70,0,0,4'h0,'h0,'h0,'hCAFEF00D,2, ob(0,0,0,0,1,'hCAFEF00D,0,0,0,0,0)), "d_rvalid");
    apply(mkv(1,1,1,'h70,0,0,4'h0,'h0,'h0,'hCAFEF00D,2, ob(1,0,0,0,0,0,1,0,4'hF,'h70,0)), "d_fgnt");

    // Latency 2 with clk_en low twice inside the wait
    apply(mkv(0,1,0,'h0,0,0,4'h0,'h0,'h0,'h0,1, Z), "e_rst");
    apply(mkv(1,1,1,'h80,0,0,4'h0,'h0,'h0,'h1111,1, ob(1,0,0,0,0,0,1,0,4'hF,'h80,0)), "e_gnt");
    apply(mkv(1,1,0,'h0,0,0,4'h0,'h0,'h0,'h1111,1, Z), "e_wait");
    apply(mkv(1,0,0,'h0,1,1,4'hF,'h90,'h2,'h1111,1, Z), "e_hold1");
    apply(mkv(1,0,0,'h0,1,1,4'hF,'h90,'h2,'h1111,1, Z), "e_hold2");
    apply(mkv(1,1,0,'h0,1,1,4'hF,'h90,'h2,'h1111,1, ob(0,1,'h1111,0,0,0,0,0,0,0,0)), "e_rvalid");
    apply(mkv(1,1,0,'h0,1,1,4'hF,'h90,'h2,'h1111,1, ob(0,0,0,1,0,0,1,1,4'hF,'h90,'h2)), "e_dgnt");
    apply(mkv(1,0,0,'h0,1,1,4'hF,'h90,'h2,'h1111,1, Z), "e_idle_noen");

    // Reset during an outstanding read drops it
    apply(mkv(0,1,0,'h0,0,0,4'h0,'h0,'h0,'h0,2, Z), "f_rst");
    apply(mkv(1,1,0,'h0,1,0,4'h0,'hA0,'h0,'h5,2, ob(0,0,0,1,0,0,1,0,4'hF,'hA0,0)), "f_gnt");
    apply(mkv(0,1,0,'h0,1,0,4'h0,'hA0,'h0,'h5,2, Z), "f_async");
    apply(mkv(1,1,0,'h0,1,1,4'hF,'hB0,'h7,'h5,2, ob(0,0,0,1,0,0,1,1,4'hF,'hB0,'h7)), "f_regnt");
    apply(mkv(1,1,0,'h0,0,0,4'h0,'h0,'h0,'h5,2, Z), "f_norv1");
    apply(mkv(1,1,0,'h0,0,0,4'h0,'h0,'h0,'h5,2, Z), "f_norv2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
